// File: rtl/ps2_host_tx_if.sv
// Bundle of the PS/2 host transmitter's command handshake and line signals.
// The slave modport is the transmitter's view; the master modport is the host-logic/pin side.
interface ps2_host_tx_if;
    logic       iStart;
    logic [7:0] iData;
    logic       iPs2Clk;
    logic       iPs2Data;
    logic       oClkLow;
    logic       oDataLow;
    logic       oBusy;
    logic       oDone;
    logic       oError;

    modport slave (
        input  iStart,
        input  iData,
        input  iPs2Clk,
        input  iPs2Data,
        output oClkLow,
        output oDataLow,
        output oBusy,
        output oDone,
        output oError
    );

    modport master (
        output iStart,
        output iData,
        output iPs2Clk,
        output iPs2Data,
        input  oClkLow,
        input  oDataLow,
        input  oBusy,
        input  oDone,
        input  oError
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift out
// 8 data bits + odd parity + stop on device clock falling edges, then check the device ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input logic          Clock,
    input logic          Reset,
    ps2_host_tx_if.slave bus
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] RTS       = 3'd2;
    localparam logic [2:0] SHIFT     = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic             clkMeta_q, clkSync_q, clkPrev_q;
    logic             dataMeta_q, dataSync_q;
    logic             fallEdge;

    logic [2:0]       state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic [3:0]       bitIdx_q, bitIdx_d;
    logic [INH_W-1:0] inhCnt_q, inhCnt_d;
    logic [TO_W-1:0]  toCnt_q, toCnt_d;
    logic             err_q, err_d;
    logic             dataLow_q, dataLow_d;
    logic             timedOut;

    // Idle bus level is high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clkMeta_q  <= 1'b1;
            clkSync_q  <= 1'b1;
            clkPrev_q  <= 1'b1;
            dataMeta_q <= 1'b1;
            dataSync_q <= 1'b1;
        end else begin
            clkMeta_q  <= bus.iPs2Clk;
            clkSync_q  <= clkMeta_q;
            clkPrev_q  <= clkSync_q;
            dataMeta_q <= bus.iPs2Data;
            dataSync_q <= dataMeta_q;
        end
    end

    assign fallEdge = clkPrev_q & ~clkSync_q;
    assign timedOut = (toCnt_q == TO_LIMIT);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        parity_d  = parity_q;
        bitIdx_d  = bitIdx_q;
        inhCnt_d  = inhCnt_q;
        toCnt_d   = toCnt_q;
        err_d     = err_q;
        dataLow_d = dataLow_q;
        case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    data_d   = bus.iData;
                    parity_d = ~^bus.iData;
                    bitIdx_d = 4'd0;
                    inhCnt_d = '0;
                    err_d    = 1'b0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inhCnt_q == INH_LAST) begin
                    state_d = RTS;
                end else begin
                    inhCnt_d = inhCnt_q + 1'b1;
                end
            end
            RTS: begin
                toCnt_d   = '0;
                dataLow_d = 1'b1;
                state_d   = SHIFT;
            end
            SHIFT: begin
                // bitIdx_q counts falling edges already taken: 0-7 data, 8 parity, 9 stop.
                if (timedOut) begin
                    err_d     = 1'b1;
                    dataLow_d = 1'b0;
                    state_d   = DONE;
                end else if (fallEdge) begin
                    toCnt_d  = '0;
                    bitIdx_d = bitIdx_q + 4'd1;
                    if (bitIdx_q < 4'd8) begin
                        dataLow_d = ~data_q[bitIdx_q[2:0]];
                    end else if (bitIdx_q == 4'd8) begin
                        dataLow_d = ~parity_q;
                    end else begin
                        dataLow_d = 1'b0;
                        state_d   = ACK;
                    end
                end else begin
                    toCnt_d = toCnt_q + 1'b1;
                end
            end
            ACK: begin
                if (timedOut) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (fallEdge) begin
                    err_d   = dataSync_q;
                    toCnt_d = '0;
                    state_d = WAIT_IDLE;
                end else begin
                    toCnt_d = toCnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (timedOut) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (clkSync_q && dataSync_q) begin
                    state_d = DONE;
                end else if (fallEdge) begin
                    toCnt_d = '0;
                end else begin
                    toCnt_d = toCnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            data_q    <= 8'h00;
            parity_q  <= 1'b0;
            bitIdx_q  <= 4'd0;
            inhCnt_q  <= '0;
            toCnt_q   <= '0;
            err_q     <= 1'b0;
            dataLow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            bitIdx_q  <= bitIdx_d;
            inhCnt_q  <= inhCnt_d;
            toCnt_q   <= toCnt_d;
            err_q     <= err_d;
            dataLow_q <= dataLow_d;
        end
    end

    // Line enables decode straight from state so an async reset releases both pins at once.
    assign bus.oClkLow  = (state_q == INHIBIT) || (state_q == RTS);
    assign bus.oDataLow = (state_q == RTS) || ((state_q == SHIFT) && dataLow_q);
    assign bus.oBusy    = (state_q != IDLE);
    assign bus.oDone    = (state_q == DONE);
    assign bus.oError   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks each command out
// of the host, driven from a table of directed vectors with hand-computed results.
module tb_ps2_host_tx;

    typedef struct {
        logic [7:0] data;
        logic       expParity;
        bit         ack;
        int         stopAfter;
        bit         glitch;
        int         resetEdge;
        logic       expErr;
    } vec_t;

    logic Clock;
    logic Reset;
    logic devClkLow;
    logic devDataLow;
    int   checks;
    int   errors;
    int   cycleCount;
    int   doneCount;
    int   doneCycle;
    logic lastErr;
    logic lastBusy;
    logic [1:0] lastLines;
    int   lastFallCycle;
    vec_t vecs[8];

    ps2_host_tx_if bus();

    ps2_host_tx #(
        .INHIBIT_CYCLES(8),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    // Open-drain bus with pull-ups: either side pulling low wins.
    assign bus.iPs2Clk  = ~(bus.oClkLow | devClkLow);
    assign bus.iPs2Data = ~(bus.oDataLow | devDataLow);

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cycleCount <= cycleCount + 1;

    always @(negedge Clock) begin
        if (bus.oDone) begin
            doneCount <= doneCount + 1;
            lastErr   <= bus.oError;
            lastBusy  <= bus.oBusy;
            lastLines <= {bus.oClkLow, bus.oDataLow};
            doneCycle <= cycleCount;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int         startDone;
        int         cnt;
        logic [7:0] rx;
        logic       rxPar;
        logic       rxStop;
        rx        = 8'h00;
        rxPar     = 1'bx;
        rxStop    = 1'bx;
        startDone = doneCount;
        @(negedge Clock);
        bus.iStart = 1'b1;
        bus.iData  = v.data;
        @(negedge Clock);
        bus.iStart = 1'b0;
        bus.iData  = 8'hFF;
        checkOutput("busyAfterStart", bus.oBusy, 1'b1);
        checkOutput("errClearedOnStart", bus.oError, 1'b0);
        cnt = 0;
        while (bus.oClkLow && !bus.oDataLow && cnt < 100) begin
            cnt++;
            @(negedge Clock);
        end
        checkOutput("inhibitCycles", cnt, 8);
        cnt = 0;
        while (bus.oClkLow && bus.oDataLow && cnt < 100) begin
            cnt++;
            @(negedge Clock);
        end
        checkOutput("rtsCycles", cnt, 1);
        checkOutput("startBitLine", bus.iPs2Data, 1'b0);
        repeat (4) @(negedge Clock);
        for (int k = 1; k <= 11; k++) begin
            if (v.stopAfter != 0 && k > v.stopAfter) break;
            if (k == 11 && v.ack) begin
                devDataLow = 1'b1;
                repeat (3) @(negedge Clock);
            end
            devClkLow     = 1'b1;
            lastFallCycle = cycleCount;
            if (k == v.resetEdge) begin
                repeat (5) @(negedge Clock);
                checkOutput("preResetDataLow", bus.oDataLow, 1'b1);
                Reset = 1'b1;
                #1;
                checkOutput("resetClkLow", bus.oClkLow, 1'b0);
                checkOutput("resetDataLow", bus.oDataLow, 1'b0);
                checkOutput("resetBusy", bus.oBusy, 1'b0);
                devClkLow = 1'b0;
                @(negedge Clock);
                Reset = 1'b0;
                repeat (300) @(negedge Clock);
                checkOutput("noDoneAfterReset", doneCount - startDone, 0);
                return;
            end
            if (v.glitch && k == 3) begin
                bus.iStart = 1'b1;
                bus.iData  = 8'h3C;
                @(negedge Clock);
                bus.iStart = 1'b0;
                repeat (9) @(negedge Clock);
            end else begin
                repeat (10) @(negedge Clock);
            end
            if (k <= 8) rx[k-1] = bus.iPs2Data;
            else if (k == 9) rxPar = bus.iPs2Data;
            else if (k == 10) rxStop = bus.iPs2Data;
            devClkLow = 1'b0;
            repeat (10) @(negedge Clock);
            if (k == 11) devDataLow = 1'b0;
        end
        cnt = 0;
        while (doneCount == startDone && cnt < 400) begin
            cnt++;
            @(negedge Clock);
        end
        repeat (40) @(negedge Clock);
        checkOutput("doneCount", doneCount - startDone, 1);
        if (v.stopAfter == 0) begin
            checkOutput("rxByte", rx, v.data);
            checkOutput("rxParity", rxPar, v.expParity);
            checkOutput("rxStop", rxStop, 1'b1);
        end else begin
            checkOutput("timeoutDelayOk", (doneCycle - lastFallCycle >= 200) && (doneCycle - lastFallCycle <= 210), 1'b1);
        end
        checkOutput("errAtDone", lastErr, v.expErr);
        checkOutput("busyAtDone", lastBusy, 1'b1);
        checkOutput("linesAtDone", lastLines, 2'b00);
        checkOutput("busyAfterDone", bus.oBusy, 1'b0);
        checkOutput("errHeld", bus.oError, v.expErr);
    endtask

    initial begin
        int busySeen;
        checks      = 0;
        errors      = 0;
        cycleCount  = 0;
        doneCount   = 0;
        doneCycle   = 0;
        Reset       = 1'b1;
        devClkLow   = 1'b0;
        devDataLow  = 1'b0;
        bus.iStart  = 1'b0;
        bus.iData   = 8'h00;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 0, 1'b0, 0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 0, 1'b0, 0, 1'b0};
        vecs[2] = '{8'h01, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0};
        vecs[3] = '{8'hA5, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1};
        vecs[4] = '{8'h96, 1'b1, 1'b1, 4, 1'b0, 0, 1'b1};
        vecs[5] = '{8'h5A, 1'b1, 1'b1, 0, 1'b1, 0, 1'b0};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 0, 1'b0, 5, 1'b0};
        vecs[7] = '{8'h7F, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0};

        repeat (3) @(negedge Clock);
        checkOutput("resetClkLow", bus.oClkLow, 1'b0);
        checkOutput("resetDataLow", bus.oDataLow, 1'b0);
        checkOutput("resetBusy", bus.oBusy, 1'b0);
        checkOutput("resetDone", bus.oDone, 1'b0);
        checkOutput("resetError", bus.oError, 1'b0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        // Device clock activity while idle must not start anything.
        busySeen = 0;
        for (int i = 0; i < 3; i++) begin
            devClkLow = 1'b1;
            repeat (5) @(negedge Clock);
            devClkLow = 1'b0;
            repeat (5) @(negedge Clock);
            if (bus.oBusy) busySeen++;
        end
        checkOutput("idleEdgesIgnoredBusy", busySeen, 0);
        checkOutput("idleEdgesIgnoredDone", doneCount, 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, Clock cycles PS/2 clock is held low before request-to-send (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, maximum Clock cycles allowed between consecutive device clock falling edges and before the first one (15 ms).
REQ-003 Clock  input  1  system clock; all logic on posedge Clock.
REQ-004 Reset  input  1  asynchronous, active-high.
REQ-005 iStart  input  1  one-cycle request to transmit iData.
REQ-006 iData  input  8  command byte to send to the keyboard.
REQ-007 iPs2Clk  input  1  PS/2 clock line as seen at the pin, asynchronous.
REQ-008 iPs2Data  input  1  PS/2 data line as seen at the pin, asynchronous.
REQ-009 oClkLow  output  1  1 = pull PS/2 clock low (open-drain enable); 0 = release.
REQ-010 oDataLow  output  1  1 = pull PS/2 data low (open-drain enable); 0 = release.
REQ-011 oBusy  output  1  high from accepted iStart until the oDone cycle inclusive.
REQ-012 oDone  output  1  one-cycle pulse at end of every accepted transfer.
REQ-013 oError  output  1  valid with oDone: 1 = timeout or missing device ack.

Function
REQ-014 iPs2Clk and iPs2Data pass through two-flop synchronizers; a falling edge is synced clock 1 then 0 on consecutive cycles.
REQ-015 States: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE, DONE.
REQ-016 IDLE: lines released; iStart latches iData, computes parity = ~^iData (odd), clears bit index, goes INHIBIT next cycle.
REQ-017 iStart while oBusy is ignored; latched byte does not change mid-transfer.
REQ-018 INHIBIT: oClkLow=1, oDataLow=0 for exactly INHIBIT_CYCLES cycles, then RTS.
REQ-019 RTS: oClkLow=1, oDataLow=1 (start bit) for exactly 1 cycle, then SHIFT with oClkLow=0, oDataLow held 1.
REQ-020 SHIFT: on falling edges 1..8 drive data bit 0..7 LSB first (oDataLow = ~bit), edge 9 drives parity, edge 10 releases data (stop bit); after edge 10 go ACK.
REQ-021 ACK: on next falling edge sample synced data; 0 = acknowledged, 1 = error flag set; go WAIT_IDLE.
REQ-022 WAIT_IDLE: wait until synced clock and data both 1, then DONE.
REQ-023 DONE: oDone=1 for one cycle, oError per flag, oBusy=1; next cycle IDLE, oBusy=0.
REQ-024 Timeout counter clears on entry to SHIFT and on every falling edge; reaching TIMEOUT_CYCLES in SHIFT, ACK or WAIT_IDLE releases both lines, sets error flag, goes DONE.
REQ-025 Counters sized ceil(log2(param+1)); no wrap-around permitted before terminal count.
REQ-026 Falling edges in IDLE, INHIBIT, RTS or DONE are ignored.
REQ-027 oError holds last value until the next accepted iStart clears it.

Reset
REQ-028 Reset asynchronously forces IDLE, oClkLow=0, oDataLow=0, oBusy=0, oDone=0, oError=0, all counters and synchronizers to idle (synced lines = 1).
REQ-029 Reset mid-transfer releases both lines immediately; no oDone is produced for the aborted transfer.

Verification (INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200, device model clock period 20 cycles)
REQ-030 iStart, iData=8'hED, device acks -> clock low 8 cycles, start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; oDone with oError=0.
REQ-031 iData=8'h00 -> parity bit 1; iData=8'h01 -> parity bit 0; both complete oError=0.
REQ-032 Device holds data high in ack slot -> oDone with oError=1, lines released.
REQ-033 Device stops clocking after 4th edge -> 200 cycles later both lines released, oDone with oError=1.
REQ-034 Second iStart during SHIFT -> ignored, transmitted byte unchanged, single oDone.
REQ-035 Reset asserted during bit 5 -> oClkLow=oDataLow=0 same cycle, no oDone; new iStart afterwards completes normally.
